// File: rtl/opcode_arbiter_pkg.sv
// Shared definitions for opcode_arbiter: FSM encodings, default sizes, one-hot helper.
// Optional fixed-priority build: define OPCODE_ARB_PRIO_EN.
package opcode_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam int NREQ_DEF    = 4;
   localparam int OPW_DEF     = 4;
   localparam int AW_DEF      = 12;
   localparam int DW_DEF      = 32;
   localparam int ALU_LAT_DEF = 1;

   // Index of the set bit; vectors of up to 8 requesters.
   function automatic int onehot2idx(input logic [7:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/opcode_arbiter_rr_pick.sv
// Combinational winner select: round-robin from ptr, or lowest index when
// OPCODE_ARB_PRIO_EN is defined (ptr is then ignored).
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt
);

   logic found;
   int   idx;

`ifdef OPCODE_ARB_PRIO_EN
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[k]) begin
            gnt[k] = 1'b1;
            found  = 1'b1;
         end
      end
   end
`else
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/opcode_arbiter.sv
// Shares one clocked opcode ALU among NREQ requesters, one op in flight at a time.
// Define OPCODE_ARB_PRIO_EN for fixed priority (lowest index) instead of round-robin.
module opcode_arbiter
   import opcode_arbiter_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int OPW     = OPW_DEF,
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int ALU_LAT = ALU_LAT_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NREQ-1:0]     req_valid,
   input  logic [NREQ*OPW-1:0] req_op,
   input  logic [NREQ*AW-1:0]  req_a,
   input  logic [NREQ*AW-1:0]  req_b,
   output logic [NREQ-1:0]     req_ready,
   output logic [NREQ-1:0]     resp_valid,
   output logic [DW-1:0]       resp_d,
   input  logic [NREQ-1:0]     resp_ready,
   output logic [OPW-1:0]      alu_op,
   output logic [AW-1:0]       alu_a,
   output logic [AW-1:0]       alu_b,
   input  logic [DW-1:0]       alu_d
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [1:0]                r_state;
   logic [NREQ-1:0]           r_gnt;
   logic [NREQ-1:0]           r_req_ready;
   logic [NREQ-1:0]           r_resp_valid;
   logic [DW-1:0]             r_resp_d;
   logic [OPW-1:0]            r_alu_op;
   logic [AW-1:0]             r_alu_a;
   logic [AW-1:0]             r_alu_b;
   logic [2:0]                r_lat;

   logic [PW-1:0]             w_ptr;
   logic [NREQ-1:0]           w_win;
   logic [PW-1:0]             w_win_idx;
   logic                      w_take;
   logic [NREQ-1:0][OPW-1:0]  w_op;
   logic [NREQ-1:0][AW-1:0]   w_a;
   logic [NREQ-1:0][AW-1:0]   w_b;

   assign w_op      = req_op;
   assign w_a       = req_a;
   assign w_b       = req_b;
   assign w_win_idx = PW'(onehot2idx(8'(w_win)));
   assign w_take    = |(resp_ready & r_gnt);

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req (req_valid),
      .ptr (w_ptr),
      .gnt (w_win)
   );

`ifdef OPCODE_ARB_PRIO_EN
   assign w_ptr = '0;
`else
   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_gnt_idx;

   assign w_gnt_idx = PW'(onehot2idx(8'(r_gnt)));
   assign w_ptr     = r_ptr;

   // Pointer moves past the served requester only once its result is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (r_state == ST_RESP && w_take) begin
         r_ptr <= (w_gnt_idx == PW'(NREQ-1)) ? '0 : w_gnt_idx + PW'(1);
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_gnt        <= '0;
         r_req_ready  <= '0;
         r_resp_valid <= '0;
         r_resp_d     <= '0;
         r_alu_op     <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_lat        <= '0;
      end else begin
         r_req_ready <= '0;
         case (r_state)
            ST_IDLE: begin
               if (|req_valid) begin
                  r_req_ready <= w_win;
                  r_gnt       <= w_win;
                  r_alu_op    <= w_op[w_win_idx];
                  r_alu_a     <= w_a[w_win_idx];
                  r_alu_b     <= w_b[w_win_idx];
                  r_lat       <= 3'(ALU_LAT);
                  r_state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // alu_d is valid at the ALU_LAT-th edge after the operands were loaded.
               if (r_lat == 3'd1) begin
                  r_resp_d     <= alu_d;
                  r_resp_valid <= r_gnt;
                  r_state      <= ST_RESP;
               end else begin
                  r_lat <= r_lat - 3'd1;
               end
            end
            ST_RESP: begin
               if (w_take) begin
                  r_resp_valid <= '0;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_d     = r_resp_d;
   assign alu_op     = r_alu_op;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;

endmodule

// File: tb/tb_opcode_arbiter.sv
// Self-checking bench for opcode_arbiter with a behavioural opcode ALU on the same clock.
module tb_opcode_arbiter;
   import opcode_arbiter_pkg::*;

   localparam int N   = 4;
   localparam int OPW = 4;
   localparam int AW  = 12;
   localparam int DW  = 32;
   localparam int LAT = 1;
   localparam int SRI = (LAT > 1) ? LAT - 1 : 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [N-1:0]       req_valid, req_ready, resp_valid, resp_ready;
   logic [N*OPW-1:0]   req_op;
   logic [N*AW-1:0]    req_a, req_b;
   logic [DW-1:0]      resp_d, alu_d;
   logic [OPW-1:0]     alu_op;
   logic [AW-1:0]      alu_a, alu_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   opcode_arbiter #(.NREQ(N), .OPW(OPW), .AW(AW), .DW(DW), .ALU_LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_d     (resp_d),
      .resp_ready (resp_ready),
      .alu_op     (alu_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_d      (alu_d)
   );

   function automatic logic [DW-1:0] alu_f(input logic [OPW-1:0] op, input logic [AW-1:0] a,
                                           input logic [AW-1:0] b);
      case (op)
         4'd0:    return 32'(a) + 32'(b);
         4'd1:    return 32'(a) - 32'(b);
         4'd2:    return 32'(a) * 32'(b);
         4'd3:    return 32'(a & b);
         4'd4:    return 32'(a | b);
         default: return {4'h0, op, a, b};
      endcase
   endfunction

   // ALU: combinational result delayed by LAT-1 register stages.
   logic [DW-1:0] alu_comb;
   logic [DW-1:0] alu_sr [1:7];
   assign alu_comb = alu_f(alu_op, alu_a, alu_b);
   always @(posedge clk) begin
      alu_sr[1] <= alu_comb;
      for (int i = 2; i < 8; i++) alu_sr[i] <= alu_sr[i-1];
   end
   assign alu_d = (LAT == 1) ? alu_comb : alu_sr[SRI];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0 = req_ready, 1 = resp_valid
   task automatic wait_bit(input int which, input int b, input string nm);
      logic seen;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
         tick();
         seen = (which == 0) ? req_ready[b] : resp_valid[b];
      end
      chk(nm, 64'(seen), 64'd1);
   endtask

   function automatic logic [N-1:0] model_pick(input logic [N-1:0] v, input int ptr);
      int p;
      int i;
      p = ptr;
`ifdef OPCODE_ARB_PRIO_EN
      p = 0;
`endif
      for (int k = 0; k < N; k++) begin
         i = (p + k) % N;
         if (v[i]) return N'(1) << i;
      end
      return '0;
   endfunction

   // Monitor / scoreboard: expected result pushed at grant, popped at handshake.
   logic [DW-1:0]           sb [$];
   int                      g_log [$];
   int                      g_cyc [$];
   int                      m_ptr = 0;
   logic [N-1:0]            s_valid = '0;
   logic [N-1:0][OPW-1:0]   s_op;
   logic [N-1:0][AW-1:0]    s_a, s_b;
   logic [N-1:0]            prv_rv = '0, last_g = '0;
   logic [DW-1:0]           prv_d = '0;
   logic                    prv_hs = 1'b0;
   int                      last_gcyc = 0;

   always @(negedge clk) begin
      int gi;
      logic hs;
      if (!rst_n) begin
         sb.delete();
         m_ptr  = 0;
         prv_rv = '0;
         prv_hs = 1'b0;
         last_g = '0;
      end else begin
         if (req_ready != '0) begin
            chk("grant_winner", 64'(req_ready), 64'(model_pick(s_valid, m_ptr)));
            gi = onehot2idx(8'(req_ready));
            chk("alu_op_load", 64'(alu_op), 64'(s_op[gi]));
            chk("alu_a_load", 64'(alu_a), 64'(s_a[gi]));
            chk("alu_b_load", 64'(alu_b), 64'(s_b[gi]));
            sb.push_back(alu_f(s_op[gi], s_a[gi], s_b[gi]));
            g_log.push_back(gi);
            g_cyc.push_back(cyc);
            last_g    = req_ready;
            last_gcyc = cyc;
         end
         if (resp_valid != '0 && prv_rv == '0) begin
            chk("resp_valid_owner", 64'(resp_valid), 64'(last_g));
            chk("resp_latency", 64'(cyc - last_gcyc), 64'(LAT));
         end
         if (prv_rv != '0 && !prv_hs) begin
            chk("resp_valid_held", 64'(resp_valid), 64'(prv_rv));
            chk("resp_d_held", 64'(resp_d), 64'(prv_d));
         end
         hs = |(resp_valid & resp_ready);
         if (hs) begin
            if (sb.size() == 0) begin
               chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
               chk("resp_d_sb", 64'(resp_d), 64'(sb.pop_front()));
            end
            gi    = onehot2idx(8'(resp_valid));
            m_ptr = (gi + 1) % N;
         end
         prv_rv = resp_valid;
         prv_d  = resp_d;
         prv_hs = hs;
      end
      s_valid = req_valid;
      s_op    = req_op;
      s_a     = req_a;
      s_b     = req_b;
   end

   typedef struct {
      int              idx;
      logic [OPW-1:0]  op;
      logic [AW-1:0]   a;
      logic [AW-1:0]   b;
      logic [DW-1:0]   d;
   } vec_t;

   vec_t tbl [7];

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic drain(input int n);
      req_valid  = '0;
      resp_ready = '1;
      for (int t = 0; t < n; t++) tick();
   endtask

   initial begin
      logic [DW-1:0]  held_d;
      logic [N-1:0]   exp_seq [5];
      tbl[0] = '{1, 4'd0, 12'd65,   12'd8,    32'd73};
      tbl[1] = '{0, 4'd1, 12'd100,  12'd30,   32'd70};
      tbl[2] = '{2, 4'd2, 12'd12,   12'd10,   32'd120};
      tbl[3] = '{3, 4'd3, 12'hF0F,  12'h0FF,  32'h0000000F};
      tbl[4] = '{1, 4'd4, 12'h800,  12'h001,  32'h00000801};
      tbl[5] = '{2, 4'd1, 12'd5,    12'd10,   32'hFFFFFFFB};
      tbl[6] = '{3, 4'd7, 12'hABC,  12'h123,  32'h07ABC123};

      // Reset with everyone requesting
      rst_n      = 1'b0;
      req_valid  = '1;
      resp_ready = '0;
      req_op     = $urandom;
      req_a      = {$urandom, $urandom};
      req_b      = {$urandom, $urandom};
      for (int t = 0; t < 3; t++) begin
         tick();
         chk("rst_req_ready", 64'(req_ready), 64'd0);
      end
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_d", 64'(resp_d), 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_alu_b", 64'(alu_b), 64'd0);
      rst_n = 1'b1;
      tick();
      chk("first_grant_req0", 64'(req_ready), 64'b0001);
      drain(6);

      // Table-driven single requests
      for (int v = 0; v < 7; v++) begin
         req_op  = $urandom;
         req_a   = {$urandom, $urandom};
         req_b   = {$urandom, $urandom};
         req_op[tbl[v].idx*OPW +: OPW] = tbl[v].op;
         req_a[tbl[v].idx*AW +: AW]    = tbl[v].a;
         req_b[tbl[v].idx*AW +: AW]    = tbl[v].b;
         req_valid  = N'(1) << tbl[v].idx;
         resp_ready = '0;
         wait_bit(0, tbl[v].idx, "tbl_req_ready");
         req_valid = '0;
         chk("tbl_alu_op", 64'(alu_op), 64'(tbl[v].op));
         chk("tbl_alu_a", 64'(alu_a), 64'(tbl[v].a));
         chk("tbl_alu_b", 64'(alu_b), 64'(tbl[v].b));
         wait_bit(1, tbl[v].idx, "tbl_resp_valid");
         chk("tbl_resp_d", 64'(resp_d), 64'(tbl[v].d));
         resp_ready = ~(N'(1) << tbl[v].idx);
         tick();
         tick();
         chk("tbl_resp_hold", 64'(resp_valid), 64'(N'(1) << tbl[v].idx));
         resp_ready = '1;
         tick();
         chk("tbl_resp_clear", 64'(resp_valid), 64'd0);
      end

      // All four continuously requesting
      do_reset();
      req_op     = {4'd4, 4'd3, 4'd2, 4'd1};
      req_a      = {$urandom, $urandom};
      req_b      = {$urandom, $urandom};
      resp_ready = '1;
      g_log.delete();
      g_cyc.delete();
      req_valid  = '1;
      for (int t = 0; t < 80 && g_log.size() < 5; t++) tick();
      chk("rr_grant_count", 64'(g_log.size() >= 5), 64'd1);
      if (g_log.size() >= 5) begin
`ifdef OPCODE_ARB_PRIO_EN
         exp_seq = '{0, 0, 0, 0, 0};
`else
         exp_seq = '{0, 1, 2, 3, 0};
`endif
         for (int k = 0; k < 5; k++) chk("rr_order", 64'(g_log[k]), 64'(exp_seq[k]));
         for (int k = 0; k < 4; k++) chk("rr_spacing", 64'(g_cyc[k+1] - g_cyc[k]), 64'(LAT + 2));
      end
      drain(10);

      // Back-pressure on requester 2
      req_valid  = 4'b0100;
      resp_ready = 4'b1011;
      wait_bit(0, 2, "bp_req_ready");
      req_valid = '0;
      wait_bit(1, 2, "bp_resp_valid");
      req_valid = 4'b0010;
      held_d    = resp_d;
      chk("bp_resp_d", 64'(held_d), 64'(alu_f(req_op[8 +: 4], req_a[24 +: 12], req_b[24 +: 12])));
      for (int t = 0; t < 10; t++) begin
         tick();
         chk("bp_valid_stable", 64'(resp_valid), 64'b0100);
         chk("bp_d_stable", 64'(resp_d), 64'(held_d));
         chk("bp_no_grant", 64'(req_ready), 64'd0);
      end
      resp_ready = '1;
      wait_bit(0, 1, "bp_next_grant");
      drain(8);

      // Reset pulse during WAIT abandons the op and clears the pointer
      req_valid = 4'b0010;
      wait_bit(0, 1, "rw_pre_grant");
      drain(6);
      req_valid  = 4'b0100;
      resp_ready = '0;
      wait_bit(0, 2, "rw_grant");
      rst_n     = 1'b0;
      req_valid = '0;
      tick();
      tick();
      rst_n      = 1'b1;
      resp_ready = '1;
      for (int t = 0; t < 8; t++) begin
         tick();
         chk("rw_no_resp", 64'(resp_valid), 64'd0);
         chk("rw_no_grant", 64'(req_ready), 64'd0);
      end
      req_valid = '1;
      tick();
      chk("rw_ptr_zero", 64'(req_ready), 64'b0001);
      drain(8);

      // Requesters 0 and 3 competing
      do_reset();
      g_log.delete();
      g_cyc.delete();
      resp_ready = '1;
      req_valid  = 4'b1001;
      for (int t = 0; t < 80 && g_log.size() < 6; t++) tick();
      chk("pair_grant_count", 64'(g_log.size() >= 6), 64'd1);
      if (g_log.size() >= 6) begin
         for (int k = 0; k < 6; k++) begin
`ifdef OPCODE_ARB_PRIO_EN
            chk("pair_prio", 64'(g_log[k]), 64'd0);
`else
            chk("pair_alternate", 64'(g_log[k]), 64'((k % 2 == 0) ? 0 : 3));
`endif
         end
      end
      drain(8);
      chk("sb_empty_end", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
